counter_seq_ctrl: RTL and testbench

//  Sequencer for the WIDTH-bit ripple counter datapath. It clears the counter, enables it, and watches cnt_q for a

---
 rtl/counter_seq_ctrl_if.sv | 28 ++
 rtl/counter_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_counter_seq_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_seq_ctrl_if.sv
// Host and counter-datapath signals of the counter sequencer, bundled with directional views.
interface counter_seq_ctrl_if #(
    parameter int WIDTH  = 4,
    parameter int PCNT_W = 8
);
    logic              start;
    logic              abort;
    logic [WIDTH-1:0]  limit;
    logic              auto_reload;
    logic [WIDTH-1:0]  cnt_q;
    logic              cnt_clr;
    logic              cnt_en;
    logic              busy;
    logic              done;
    logic              stall_err;
    logic [PCNT_W-1:0] period_cnt;

    // Environment side: host requests plus the counter value coming back.
    modport master (
        output start, abort, limit, auto_reload, cnt_q,
        input  cnt_clr, cnt_en, busy, done, stall_err, period_cnt
    );

    modport slave (
        input  start, abort, limit, auto_reload, cnt_q,
        output cnt_clr, cnt_en, busy, done, stall_err, period_cnt
    );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Sequencer for a ripple counter: clear phase, counted run to a terminal value, optional
// auto-reload, abort handling and a watchdog that flags a counter which stops advancing.
module counter_seq_ctrl #(
    parameter int WIDTH      = 4,
    parameter int CLR_CYCLES = 2,
    parameter int STALL_MAX  = 16,
    parameter int PCNT_W     = 8
) (
    input  logic               clk,
    input  logic               clear,
    counter_seq_ctrl_if.slave  bus
);
    localparam int CLR_W   = $clog2(CLR_CYCLES + 1);
    localparam int STALL_W = $clog2(STALL_MAX + 1);

    typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;

    state_t              state_reg, state_next;
    logic [CLR_W-1:0]    clr_cnt_reg, clr_cnt_next;
    logic [STALL_W-1:0]  stall_cnt_reg, stall_cnt_next, stall_eff;
    logic [WIDTH-1:0]    limit_reg, prev_q_reg;
    logic                reload_reg;
    logic                accept, match, stall_hit;

    logic                cnt_clr_reg, cnt_en_reg, busy_reg, done_reg, stall_err_reg;
    logic                cnt_clr_next, cnt_en_next, busy_next, done_next, stall_err_next;
    logic [PCNT_W-1:0]   period_cnt_reg, period_cnt_next;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_reg     <= IDLE;
            clr_cnt_reg   <= '0;
            stall_cnt_reg <= '0;
            limit_reg     <= '0;
            reload_reg    <= 1'b0;
            prev_q_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            clr_cnt_reg   <= clr_cnt_next;
            stall_cnt_reg <= stall_cnt_next;
            prev_q_reg    <= bus.cnt_q;
            if (accept) begin
                limit_reg  <= bus.limit;
                reload_reg <= bus.auto_reload;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        clr_cnt_next   = clr_cnt_reg;
        stall_cnt_next = stall_cnt_reg;
        accept         = (state_reg == IDLE) && bus.start && !bus.abort;
        match          = (bus.cnt_q == limit_reg);
        // A counter that moved this cycle restarts the stall window from zero.
        stall_eff      = (bus.cnt_q != prev_q_reg) ? '0 : stall_cnt_reg;
        stall_hit      = (stall_eff == STALL_W'(STALL_MAX - 1));
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next   = CLR;
                    clr_cnt_next = '0;
                end
            end
            CLR: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else if (clr_cnt_reg == CLR_W'(CLR_CYCLES - 1)) begin
                    state_next     = RUN;
                    stall_cnt_next = '0;
                end else begin
                    clr_cnt_next = clr_cnt_reg + 1'b1;
                end
            end
            RUN: begin
                if (bus.abort || stall_hit) begin
                    state_next = IDLE;
                end else if (match) begin
                    if (reload_reg) begin
                        state_next   = CLR;
                        clr_cnt_next = '0;
                    end else begin
                        state_next = DONE;
                    end
                end else begin
                    stall_cnt_next = stall_eff + 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so they appear registered alongside it.
    always_comb begin
        cnt_clr_next    = (state_next == CLR);
        cnt_en_next     = (state_next == RUN);
        busy_next       = (state_next != IDLE);
        done_next       = (state_next == DONE);
        stall_err_next  = stall_err_reg;
        period_cnt_next = period_cnt_reg;
        if (accept) begin
            stall_err_next  = 1'b0;
            period_cnt_next = '0;
        end
        if (state_reg == RUN && !bus.abort) begin
            if (stall_hit) begin
                stall_err_next = 1'b1;
            end else if (match && period_cnt_reg != '1) begin
                period_cnt_next = period_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            cnt_clr_reg    <= 1'b0;
            cnt_en_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            stall_err_reg  <= 1'b0;
            period_cnt_reg <= '0;
        end else begin
            cnt_clr_reg    <= cnt_clr_next;
            cnt_en_reg     <= cnt_en_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            stall_err_reg  <= stall_err_next;
            period_cnt_reg <= period_cnt_next;
        end
    end

    assign bus.cnt_clr    = cnt_clr_reg;
    assign bus.cnt_en     = cnt_en_reg;
    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.stall_err  = stall_err_reg;
    assign bus.period_cnt = period_cnt_reg;
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboard bench for counter_seq_ctrl: each run's expected summary is queued at stimulus time
// and checked by a monitor when busy falls; a second instance checks period_cnt saturation.
module tb_counter_seq_ctrl;
    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    counter_seq_ctrl_if #(.WIDTH(4), .PCNT_W(8)) bus1();
    counter_seq_ctrl_if #(.WIDTH(4), .PCNT_W(2)) bus2();

    counter_seq_ctrl #(.WIDTH(4), .CLR_CYCLES(2), .STALL_MAX(16), .PCNT_W(8)) dut1 (
        .clk(clk), .clear(clear), .bus(bus1)
    );
    counter_seq_ctrl #(.WIDTH(4), .CLR_CYCLES(2), .STALL_MAX(16), .PCNT_W(2)) dut2 (
        .clk(clk), .clear(clear), .bus(bus2)
    );

    // Counter datapath models: clear wins, then count on enable; q1 can be frozen at 2.
    logic       freeze = 1'b0;
    logic [3:0] q1 = '0;
    logic [3:0] q2 = '0;
    always @(posedge clk) begin
        if (freeze)              q1 <= 4'd2;
        else if (bus1.cnt_clr)   q1 <= '0;
        else if (bus1.cnt_en)    q1 <= q1 + 4'd1;
        if (bus2.cnt_clr)        q2 <= '0;
        else if (bus2.cnt_en)    q2 <= q2 + 4'd1;
    end
    assign bus1.cnt_q = q1;
    assign bus2.cnt_q = q2;

    typedef struct {
        int   runs;
        int   en;
        int   dones;
        logic stall;
        int   pcnt;
        int   last_q;
    } exp_t;

    exp_t sb[$];
    int   sb2[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting", name);
    endtask

    task automatic push(input int runs, input int en, input int dones, input logic stall,
                        input int pcnt, input int last_q);
        exp_t e;
        e.runs = runs; e.en = en; e.dones = dones; e.stall = stall; e.pcnt = pcnt; e.last_q = last_q;
        sb.push_back(e);
    endtask

    // Main monitor: accumulates per-run activity and checks it when the sequencer goes idle.
    initial begin
        int   m_runs = 0, m_en = 0, m_dones = 0, m_last = -1, clr_len = 0;
        logic en_prev = 1'b0, busy_prev = 1'b0, done_prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus1.cnt_en && !en_prev) begin
                m_runs++;
                check("clr_phase_len", clr_len, 2);
            end
            clr_len = bus1.cnt_clr ? clr_len + 1 : 0;
            if (bus1.cnt_en) begin
                m_en++;
                m_last = int'(bus1.cnt_q);
            end
            if (bus1.done) m_dones++;
            if (busy_prev && !bus1.busy) begin
                if (sb.size() == 0) begin
                    timeout("unexpected_run_end");
                end else begin
                    e = sb.pop_front();
                    check("runs", m_runs, e.runs);
                    check("en_cycles", m_en, e.en);
                    check("done_pulses", m_dones, e.dones);
                    check("stall_err", int'(bus1.stall_err), int'(e.stall));
                    check("period_cnt", int'(bus1.period_cnt), e.pcnt);
                    check("last_en_q", m_last, e.last_q);
                    check("busy_after_done", int'(done_prev), (e.dones != 0) ? 1 : 0);
                end
                m_runs = 0; m_en = 0; m_dones = 0; m_last = -1;
            end
            en_prev   = bus1.cnt_en;
            busy_prev = bus1.busy;
            done_prev = bus1.done;
        end
    end

    // Second monitor: period_cnt seen at the start of every run of the narrow instance.
    initial begin
        logic en2_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus2.cnt_en && !en2_prev) begin
                if (sb2.size() == 0) timeout("unexpected_run2");
                else check("pcnt_sat", int'(bus2.period_cnt), sb2.pop_front());
            end
            en2_prev = bus2.cnt_en;
        end
    end

    task automatic do_start(input int lim, input bit rel);
        logic [3:0] l4;
        l4 = lim[3:0];
        @(negedge clk);
        bus1.limit       = l4;
        bus1.auto_reload = rel;
        bus1.start       = 1'b1;
        @(negedge clk);
        bus1.start       = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max);
        int n = 0;
        while (bus1.busy && n < max) begin
            @(negedge clk);
            n++;
        end
        if (bus1.busy) timeout(name);
        @(negedge clk);
    endtask

    task automatic wait_q(input string name, input int v, input int max);
        int n = 0;
        while (!(bus1.cnt_en && int'(q1) == v) && n < max) begin
            @(negedge clk);
            n++;
        end
        if (!(bus1.cnt_en && int'(q1) == v)) timeout(name);
    endtask

    initial begin
        int n;
        clear = 1'b1;
        bus1.start = 1'b0; bus1.abort = 1'b0; bus1.limit = '0; bus1.auto_reload = 1'b0;
        bus2.start = 1'b0; bus2.abort = 1'b0; bus2.limit = '0; bus2.auto_reload = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(bus1.busy), 0);
        check("rst_done", int'(bus1.done), 0);
        check("rst_cnt_en", int'(bus1.cnt_en), 0);
        check("rst_cnt_clr", int'(bus1.cnt_clr), 0);
        check("rst_stall_err", int'(bus1.stall_err), 0);
        check("rst_period_cnt", int'(bus1.period_cnt), 0);
        clear = 1'b0;

        // One-shot to 5: counts 0..5 with enable, one done, one period.
        push(1, 6, 1, 1'b0, 1, 5);
        do_start(5, 1'b0);
        wait_idle("oneshot5", 50);

        // Auto-reload to 3, aborted once the fourth period has completed.
        push(4, 16, 0, 1'b0, 4, 3);
        do_start(3, 1'b1);
        n = 0;
        while (int'(bus1.period_cnt) != 4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (int'(bus1.period_cnt) != 4) timeout("reload_periods");
        bus1.abort = 1'b1;
        @(negedge clk);
        bus1.abort = 1'b0;
        check("abort_busy", int'(bus1.busy), 0);
        wait_idle("reload_abort", 5);

        // Terminal count 0 and terminal count 15.
        push(1, 1, 1, 1'b0, 1, 0);
        do_start(0, 1'b0);
        wait_idle("limit0", 20);
        push(1, 16, 1, 1'b0, 1, 15);
        do_start(15, 1'b0);
        wait_idle("limit15", 60);

        // Frozen counter trips the watchdog after 16 RUN cycles; next start clears the flag.
        freeze = 1'b1;
        push(1, 16, 0, 1'b1, 0, 2);
        do_start(9, 1'b0);
        wait_idle("stall", 60);
        freeze = 1'b0;
        push(1, 2, 1, 1'b0, 1, 1);
        do_start(1, 1'b0);
        check("stall_cleared", int'(bus1.stall_err), 0);
        wait_idle("after_stall", 30);

        // Start with a new limit while running is ignored; the run still ends at 5.
        push(1, 6, 1, 1'b0, 1, 5);
        do_start(5, 1'b0);
        wait_q("run_q2", 2, 30);
        bus1.limit = 4'd2;
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        wait_idle("start_in_run", 50);

        // Start together with abort in IDLE stays idle.
        @(negedge clk);
        bus1.start = 1'b1;
        bus1.abort = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        bus1.abort = 1'b0;
        check("start_abort_idle", int'(bus1.busy), 0);

        // Clear mid-RUN drops every output without waiting for a clock edge.
        push(1, 5, 0, 1'b0, 0, 4);
        do_start(9, 1'b0);
        wait_q("run_q4", 4, 30);
        #1 clear = 1'b1;
        #1;
        check("aclr_busy", int'(bus1.busy), 0);
        check("aclr_cnt_en", int'(bus1.cnt_en), 0);
        check("aclr_cnt_clr", int'(bus1.cnt_clr), 0);
        check("aclr_done", int'(bus1.done), 0);
        repeat (2) @(negedge clk);
        clear = 1'b0;

        // Narrow period counter: five reloads of limit 1 saturate at 3.
        sb2.push_back(0); sb2.push_back(1); sb2.push_back(2);
        sb2.push_back(3); sb2.push_back(3); sb2.push_back(3);
        @(negedge clk);
        bus2.limit       = 4'd1;
        bus2.auto_reload = 1'b1;
        bus2.start       = 1'b1;
        @(negedge clk);
        bus2.start       = 1'b0;
        n = 0;
        while (sb2.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb2.size() != 0) timeout("sat_runs");
        bus2.abort = 1'b1;
        @(negedge clk);
        bus2.abort = 1'b0;
        check("sat_abort_busy", int'(bus2.busy), 0);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        check("sb2_drained", sb2.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
